pc_branch_sequencer: RTL
========================

# pc_branch_sequencer

Program-counter sequencer for the SPARC integer datapath. It holds the architectural PC/nPC pair and implements delayed control transfer for Bicc, CALL and JMPL. It evaluates the 16 integer branch conditions against the icc flags and computes displacement targets. It also annuls delay-slot instructions as the annul bit requires. It sits between decode/execute and the instruction-fetch address, and advances once per retired instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; nPC resets to RESET_PC+4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- step  in  1  advance one instruction this cycle; when low, all state holds.
- is_bicc  in  1  instruction at pc is Bicc.
- is_call  in  1  instruction at pc is CALL.
- is_jmpl  in  1  instruction at pc is JMPL.
- cond  in  4  Bicc cond field.
- annul_bit  in  1  Bicc a field.
- icc  in  4  {N,Z,V,C}.
- disp22  in  22  Bicc word displacement.
- disp30  in  30  CALL word displacement.
- jmpl_tgt  in  32  JMPL computed target (rs1+op2).
- pc  out  32  current PC (fetch address).
- npc  out  32  next PC.
- squash  out  1  instruction at pc is annulled; it must not write state.
- taken  out  1  last evaluated transfer was taken.
- fault  out  1  misaligned JMPL target; sticky until reset.

## Operation
- FSM states: RUN, SQUASH, FAULT. Reset -> RUN, with pc=RESET_PC, npc=RESET_PC+4, squash=0, taken=0, fault=0.
- In RUN with step=1:
  - Priority when several type inputs are asserted: is_jmpl > is_call > is_bicc. With none asserted: pc<=npc, npc<=npc+4, taken<=0.
  - Bicc target = pc + (sext32(disp22) << 2).
  - CALL target = pc + (disp30 << 2). The shift makes the result 32 bits; no sign extension is needed.
  - JMPL target = jmpl_tgt.
  - All adds are modulo 2^32; carry-out is discarded.
  - Taken decision:
    - CALL/JMPL: always taken.
    - Bicc cond: 0 BN=0; 1 BE=Z; 2 BLE=Z|(N^V); 3 BL=N^V; 4 BLEU=C|Z; 5 BCS=C; 6 BNEG=N; 7 BVS=V.
    - Bicc cond 8–F: the complements of 0–7 (8 is BA=1).
  - If taken: pc<=npc, npc<=target. Otherwise: pc<=npc, npc<=npc+4. taken<=decision.
  - Annul applies to Bicc with annul_bit=1 only. It triggers if cond==4'b1000 (BA), or if the branch is not taken. When it triggers: next state SQUASH, squash<=1.
  - JMPL with jmpl_tgt[1:0]!=0: pc/npc unchanged, fault<=1, next state FAULT.
- In SQUASH with step=1:
  - All instruction inputs are ignored.
  - pc<=npc, npc<=npc+4, squash<=0, taken<=0, next state RUN.
- FAULT: all inputs except rst_n are ignored; state holds until reset.
- step=0 in any state: no change.
- rst_n=0 overrides step in the same cycle.

## Timing
- All outputs are registered. The effect of a step is visible on pc/npc/squash/taken the cycle after the edge that samples it: 1-cycle latency.
- Inputs are sampled only on edges where step=1.
- A squashed instruction consumes exactly one step.
- Back-to-back steps are supported every cycle. There are no bubbles and no handshake beyond step.
- Reset mid-sequence, including in SQUASH or FAULT, discards any pending annul and fault within one edge.
- Wrap-around: RESET_PC=32'hFFFF_FFFC gives npc=0 after reset, with no error.

## Structure
Shared package (sparc_pkg) holds:
- cond encodings (COND_BN…COND_BVC),
- the state enum {RUN, SQUASH, FAULT},
- the icc bit indices.

One sub-module, branch_target_calc, is combinational. It takes pc, disp22, disp30, jmpl_tgt and the type select, and returns the 32-bit target plus a misalign flag. Condition evaluation and the FSM stay in the top module.

## Test plan
- Reset with RESET_PC=0 -> pc=0, npc=4, squash=0, taken=0, fault=0; step held low for 3 cycles -> unchanged.
- pc=0x100, npc=0x104, Bicc cond=9 (BNE), a=0, Z=0, disp22=22'h3FFFFF -> pc=0x104, npc=0xFC, taken=1, squash=0.
- Same state, cond=1 (BE), a=1, Z=0 -> pc=0x104, npc=0x108, squash=1. Next step with is_call=1 driven -> pc=0x108, npc=0x10C, squash=0 (input ignored).
- BA, a=1, disp22=4 at pc=0x200, npc=0x204 -> pc=0x204, npc=0x210, squash=1, taken=1.
- CALL at pc=0, npc=4, disp30=30'h3FFFFFFF -> pc=4, npc=0xFFFFFFFC. RESET_PC=0xFFFFFFFC reset -> npc=0.
- JMPL jmpl_tgt=0x203 -> fault=1, pc/npc hold under further steps. rst_n low one edge -> RUN, fault=0, pc=RESET_PC.

Source files
------------

// File: rtl/sparc_pkg.sv
// Shared definitions for the SPARC PC sequencer: branch conditions, FSM states, icc bit positions.
// Latency: none (definitions only).
// Backpressure: not applicable.
package sparc_pkg;

  // Bicc cond field encodings; codes 8-F are the logical complements of codes 0-7
  localparam logic [3:0] COND_BN   = 4'h0;
  localparam logic [3:0] COND_BE   = 4'h1;
  localparam logic [3:0] COND_BLE  = 4'h2;
  localparam logic [3:0] COND_BL   = 4'h3;
  localparam logic [3:0] COND_BLEU = 4'h4;
  localparam logic [3:0] COND_BCS  = 4'h5;
  localparam logic [3:0] COND_BNEG = 4'h6;
  localparam logic [3:0] COND_BVS  = 4'h7;
  localparam logic [3:0] COND_BA   = 4'h8;
  localparam logic [3:0] COND_BNE  = 4'h9;
  localparam logic [3:0] COND_BG   = 4'hA;
  localparam logic [3:0] COND_BGE  = 4'hB;
  localparam logic [3:0] COND_BGU  = 4'hC;
  localparam logic [3:0] COND_BCC  = 4'hD;
  localparam logic [3:0] COND_BPOS = 4'hE;
  localparam logic [3:0] COND_BVC  = 4'hF;

  // Bit positions inside the icc nibble {N,Z,V,C}
  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  // Sequencer states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // Which control-transfer flavour the target calculator should produce
  typedef enum logic [1:0] {
    TGT_BICC = 2'd0,
    TGT_CALL = 2'd1,
    TGT_JMPL = 2'd2
  } tgt_sel_t;

endpackage

// File: rtl/branch_target_calc.sv
// Computes the control-transfer target for Bicc/CALL/JMPL and flags misaligned JMPL targets.
// Latency: purely combinational.
// Backpressure: none; output follows inputs every cycle.
module branch_target_calc
  import sparc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [21:0] disp22,
  input  logic [29:0] disp30,
  input  logic [31:0] jmpl_tgt,
  input  tgt_sel_t    tgt_sel,
  output logic [31:0] target,
  output logic        misalign
);

  // Word displacements become byte offsets; adds wrap modulo 2^32
  always_comb begin
    target   = '0;
    misalign = 1'b0;
    case (tgt_sel)
      TGT_BICC: target = pc + {{8{disp22[21]}}, disp22, 2'b00};
      TGT_CALL: target = pc + {disp30, 2'b00};
      TGT_JMPL: begin
        target   = jmpl_tgt;
        misalign = (jmpl_tgt[1:0] != 2'b00);
      end
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/pc_branch_sequencer.sv
// Holds PC/nPC and implements delayed control transfer with annul for Bicc, CALL and JMPL.
// Latency: one cycle from a sampled step to updated pc/npc/squash/taken/fault.
// Backpressure: none; step low freezes all state, a step may be issued every cycle.
module pc_branch_sequencer
  import sparc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        is_bicc,
  input  logic        is_call,
  input  logic        is_jmpl,
  input  logic [3:0]  cond,
  input  logic        annul_bit,
  input  logic [3:0]  icc,
  input  logic [21:0] disp22,
  input  logic [29:0] disp30,
  input  logic [31:0] jmpl_tgt,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        squash,
  output logic        taken,
  output logic        fault
);

  state_t      state;
  tgt_sel_t    tgt_sel;
  logic [31:0] target;
  logic        misalign;
  logic        cond_base;
  logic        cond_true;

  // Type priority: JMPL over CALL over Bicc
  always_comb begin
    tgt_sel = TGT_BICC;
    if (is_jmpl)      tgt_sel = TGT_JMPL;
    else if (is_call) tgt_sel = TGT_CALL;
  end

  branch_target_calc u_tgt (
    .pc       (pc),
    .disp22   (disp22),
    .disp30   (disp30),
    .jmpl_tgt (jmpl_tgt),
    .tgt_sel  (tgt_sel),
    .target   (target),
    .misalign (misalign)
  );

  // Evaluate the lower eight conditions; cond[3] selects the complement
  always_comb begin
    cond_base = 1'b0;
    case (cond[2:0])
      3'd0: cond_base = 1'b0;
      3'd1: cond_base = icc[ICC_Z];
      3'd2: cond_base = icc[ICC_Z] | (icc[ICC_N] ^ icc[ICC_V]);
      3'd3: cond_base = icc[ICC_N] ^ icc[ICC_V];
      3'd4: cond_base = icc[ICC_C] | icc[ICC_Z];
      3'd5: cond_base = icc[ICC_C];
      3'd6: cond_base = icc[ICC_N];
      3'd7: cond_base = icc[ICC_V];
      default: cond_base = 1'b0;
    endcase
    cond_true = cond_base ^ cond[3];
  end

  // Sequencer FSM with registered architectural outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      pc     <= RESET_PC;
      npc    <= RESET_PC + 32'd4;
      squash <= 1'b0;
      taken  <= 1'b0;
      fault  <= 1'b0;
    end else if (step) begin
      case (state)
        RUN: begin
          if (is_jmpl) begin
            if (misalign) begin
              // Leave pc/npc pointing at the faulting instruction
              fault <= 1'b1;
              state <= FAULT;
            end else begin
              pc    <= npc;
              npc   <= target;
              taken <= 1'b1;
            end
          end else if (is_call) begin
            pc    <= npc;
            npc   <= target;
            taken <= 1'b1;
          end else if (is_bicc) begin
            pc    <= npc;
            npc   <= cond_true ? target : npc + 32'd4;
            taken <= cond_true;
            // Annulled delay slot: BA,a always; other conditionals only when untaken
            if (annul_bit && ((cond == COND_BA) || !cond_true)) begin
              squash <= 1'b1;
              state  <= SQUASH;
            end
          end else begin
            pc    <= npc;
            npc   <= npc + 32'd4;
            taken <= 1'b0;
          end
        end
        SQUASH: begin
          // The annulled instruction consumes this step; its inputs are ignored
          pc     <= npc;
          npc    <= npc + 32'd4;
          squash <= 1'b0;
          taken  <= 1'b0;
          state  <= RUN;
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= FAULT;
          fault <= 1'b1;
        end
      endcase
    end
  end

endmodule
